ps2_poly_decoder: RTL and testbench

PS2_POLY_DECODER -- requirements
Module: ps2_poly_decoder

---
 rtl/ps2_poly_pkg.sv | 22 ++
 rtl/ps2_keymap.sv | 47 ++++
 rtl/ps2_poly_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_poly_decoder.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_poly_pkg.sv
// Shared constants and types for the PS/2 polyphonic note decoder.
package ps2_poly_pkg;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  // Bytes following E1 that belong to the Pause make/break sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Keymap result meaning "no note for this key".
  localparam int NOTE_UNMAPPED = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } parser_state_t;

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scan-code to note table; i_key is {extended, byte}.
module ps2_keymap
  import ps2_poly_pkg::*;
#(
  parameter int NOTE_W = 8
) (
  input  logic [8:0]        i_key,
  output logic [NOTE_W-1:0] o_note
);

  logic [6:0] w_code;

  // Bottom letter row z..m gives notes 1..7, home/top rows continue upward.
  always_comb begin
    w_code = 7'(NOTE_UNMAPPED);
    case (i_key)
      9'h01A: w_code = 7'd1;   // z
      9'h022: w_code = 7'd2;   // x
      9'h021: w_code = 7'd3;   // c
      9'h02A: w_code = 7'd4;   // v
      9'h032: w_code = 7'd5;   // b
      9'h031: w_code = 7'd6;   // n
      9'h03A: w_code = 7'd7;   // m
      9'h01C: w_code = 7'd8;   // a
      9'h01D: w_code = 7'd9;   // w
      9'h01B: w_code = 7'd10;  // s
      9'h024: w_code = 7'd11;  // e
      9'h023: w_code = 7'd12;  // d
      9'h02B: w_code = 7'd13;  // f
      9'h02C: w_code = 7'd14;  // t
      9'h034: w_code = 7'd15;  // g
      9'h035: w_code = 7'd16;  // y
      9'h033: w_code = 7'd17;  // h
      9'h03C: w_code = 7'd18;  // u
      9'h03B: w_code = 7'd19;  // j
      9'h042: w_code = 7'd20;  // k
      9'h044: w_code = 7'd21;  // o
      9'h04B: w_code = 7'd22;  // l
      9'h171: w_code = 7'd56;  // E0 71 Delete
      9'h16C: w_code = 7'd63;  // E0 6C Home
      default: w_code = 7'(NOTE_UNMAPPED);
    endcase
  end

  assign o_note = NOTE_W'(w_code);

endmodule

// File: rtl/ps2_poly_decoder.sv
// PS/2 scan-code parser feeding an LRU-stealing polyphonic voice table.
module ps2_poly_decoder
  import ps2_poly_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 8
) (
  input  logic                         iClk,
  input  logic                         iReset_n,
  input  logic                         iFlag,
  input  logic [7:0]                   iData,
  output logic [NUM_VOICES-1:0]        oVoiceValid,
  output logic [NUM_VOICES*NOTE_W-1:0] oVoiceNote,
  output logic                         oEvent,
  output logic                         oEventRelease,
  output logic [NOTE_W-1:0]            oEventNote,
  output logic                         oSteal
);

  localparam int AGE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  parser_state_t r_state, w_state_nx;
  logic [2:0] r_skip, w_skip_nx;
  logic       w_done, w_ext, w_brk;

  // Parser: consume one byte per iFlag, emit a completed {ext,brk,byte} code.
  always_comb begin
    w_state_nx = r_state;
    w_skip_nx  = r_skip;
    w_done     = 1'b0;
    w_ext      = 1'b0;
    w_brk      = 1'b0;
    if (iFlag) begin
      case (r_state)
        ST_IDLE: begin
          if (iData == BYTE_E0)      w_state_nx = ST_EXT;
          else if (iData == BYTE_F0) w_state_nx = ST_BRK;
          else if (iData == BYTE_E1) begin
            w_state_nx = ST_SKIP;
            w_skip_nx  = PAUSE_SKIP;
          end else w_done = 1'b1;
        end
        ST_EXT: begin
          if (iData == BYTE_F0)      w_state_nx = ST_EXT_BRK;
          else if (iData != BYTE_E0) begin
            w_done = 1'b1;
            w_ext  = 1'b1;
          end
        end
        ST_BRK: begin
          w_done = 1'b1;
          w_brk  = 1'b1;
        end
        ST_EXT_BRK: begin
          w_done = 1'b1;
          w_ext  = 1'b1;
          w_brk  = 1'b1;
        end
        ST_SKIP: begin
          w_skip_nx = r_skip - 3'd1;
          if (r_skip <= 3'd1) begin
            w_skip_nx  = '0;
            w_state_nx = ST_IDLE;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
      if (w_done) w_state_nx = ST_IDLE;
    end
  end

  logic       r_cv, r_cbrk;
  logic [8:0] r_ckey;

  // Parser state and the one-stage code register that sets the latency of 1.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
      r_cv    <= 1'b0;
      r_cbrk  <= 1'b0;
      r_ckey  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_skip  <= w_skip_nx;
      r_cv    <= w_done;
      r_cbrk  <= w_brk;
      r_ckey  <= {w_ext, iData};
    end
  end

  logic [NOTE_W-1:0] w_map_note;

  ps2_keymap #(.NOTE_W(NOTE_W)) u_keymap (
    .i_key  (r_ckey),
    .o_note (w_map_note)
  );

  logic [NUM_VOICES-1:0] r_valid, w_valid_nx;
  logic [8:0]            r_key  [NUM_VOICES];
  logic [8:0]            w_key_nx [NUM_VOICES];
  logic [NOTE_W-1:0]     r_note [NUM_VOICES];
  logic [NOTE_W-1:0]     w_note_nx [NUM_VOICES];
  logic [AGE_W-1:0]      r_age  [NUM_VOICES];
  logic [AGE_W-1:0]      w_age_nx [NUM_VOICES];
  logic                  w_hit, w_free;
  logic [AGE_W-1:0]      w_hit_idx, w_slot;
  logic                  w_ev, w_ev_rel, w_steal;
  logic [NOTE_W-1:0]     w_ev_note;

  // Voice table update: hit search, free/oldest slot choice, rank maintenance.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_free    = 1'b0;
    w_slot    = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (r_valid[v] && r_key[v] == r_ckey) begin
        w_hit     = 1'b1;
        w_hit_idx = AGE_W'(v);
      end
      if (!r_valid[v] && !w_free) begin
        w_free = 1'b1;
        w_slot = AGE_W'(v);
      end
    end
    if (!w_free) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++)
        if (r_age[v] == AGE_W'(NUM_VOICES - 1)) w_slot = AGE_W'(v);
    end

    w_valid_nx = r_valid;
    w_key_nx   = r_key;
    w_note_nx  = r_note;
    w_age_nx   = r_age;
    w_ev       = 1'b0;
    w_ev_rel   = oEventRelease;
    w_ev_note  = oEventNote;
    w_steal    = 1'b0;

    if (r_cv && w_map_note != NOTE_W'(NOTE_UNMAPPED)) begin
      if (!r_cbrk && !w_hit) begin
        // Every other valid voice is younger than the target's old rank
        // (free slot, or the oldest voice when stealing), so all age by one.
        for (int unsigned v = 0; v < NUM_VOICES; v++)
          if (r_valid[v]) w_age_nx[v] = r_age[v] + 1'b1;
        w_valid_nx[w_slot] = 1'b1;
        w_key_nx[w_slot]   = r_ckey;
        w_note_nx[w_slot]  = w_map_note;
        w_age_nx[w_slot]   = '0;
        w_ev               = 1'b1;
        w_ev_rel           = 1'b0;
        w_ev_note          = w_map_note;
        w_steal            = !w_free;
      end else if (r_cbrk && w_hit) begin
        for (int unsigned v = 0; v < NUM_VOICES; v++)
          if (r_valid[v] && r_age[v] > r_age[w_hit_idx]) w_age_nx[v] = r_age[v] - 1'b1;
        w_valid_nx[w_hit_idx] = 1'b0;
        w_key_nx[w_hit_idx]   = '0;
        w_note_nx[w_hit_idx]  = '0;
        w_age_nx[w_hit_idx]   = '0;
        w_ev                  = 1'b1;
        w_ev_rel              = 1'b1;
        w_ev_note             = r_note[w_hit_idx];
      end
    end
  end

  // Voice table and event output registers.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_valid       <= '0;
      oEvent        <= 1'b0;
      oEventRelease <= 1'b0;
      oEventNote    <= '0;
      oSteal        <= 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_key[v]  <= '0;
        r_note[v] <= '0;
        r_age[v]  <= '0;
      end
    end else begin
      r_valid       <= w_valid_nx;
      r_key         <= w_key_nx;
      r_note        <= w_note_nx;
      r_age         <= w_age_nx;
      oEvent        <= w_ev;
      oEventRelease <= w_ev_rel;
      oEventNote    <= w_ev_note;
      oSteal        <= w_steal;
    end
  end

  assign oVoiceValid = r_valid;

  for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_out
    assign oVoiceNote[gv*NOTE_W +: NOTE_W] = r_note[gv];
  end

endmodule

// File: tb/tb_ps2_poly_decoder.sv
// Self-checking bench for ps2_poly_decoder: directed scenarios plus random traffic.
module tb_ps2_poly_decoder;

  localparam int NV = 4;
  localparam int NW = 8;

  logic iClk = 1'b0, iReset_n = 1'b0, iFlag = 1'b0;
  logic [7:0] iData = '0;
  logic [NV-1:0] oVoiceValid;
  logic [NV*NW-1:0] oVoiceNote;
  logic oEvent, oEventRelease, oSteal;
  logic [NW-1:0] oEventNote;

  ps2_poly_decoder #(.NUM_VOICES(NV), .NOTE_W(NW)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iFlag(iFlag), .iData(iData),
    .oVoiceValid(oVoiceValid), .oVoiceNote(oVoiceNote), .oEvent(oEvent),
    .oEventRelease(oEventRelease), .oEventNote(oEventNote), .oSteal(oSteal)
  );

  always #5 iClk = ~iClk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge iClk) cyc++;

  // Event log: {release, steal, note} and the edge number it appeared on.
  logic [NW+1:0] ev_q[$];
  int ev_cyc[$];
  always @(negedge iClk) if (oEvent) begin
    ev_q.push_back({oEventRelease, oSteal, oEventNote});
    ev_cyc.push_back(cyc);
  end

  // ---------------- reference model ----------------
  function automatic int ref_note(input bit ext, input logic [7:0] b);
    if (ext) begin
      if (b == 8'h71) return 56;
      if (b == 8'h6C) return 63;
      return 0;
    end
    case (b)
      8'h1A: return 1;  8'h22: return 2;  8'h21: return 3;  8'h2A: return 4;
      8'h32: return 5;  8'h3A: return 7;  8'h1C: return 8;  8'h1B: return 10;
      default: return 0;
    endcase
  endfunction

  bit p_ext, p_brk; int p_skip;
  bit m_valid[NV]; int m_key[NV]; int m_note[NV];
  int order[$];                     // slot indices, most recent first
  bit e_ev, e_rel, e_steal; int e_note;
  bit pend; logic [7:0] pend_b;

  task automatic model_reset();
    p_ext = 0; p_brk = 0; p_skip = 0; order = {};
    for (int i = 0; i < NV; i++) begin m_valid[i] = 0; m_key[i] = 0; m_note[i] = 0; end
    e_ev = 0; e_rel = 0; e_steal = 0; e_note = 0; pend = 0; pend_b = 0;
  endtask

  task automatic apply_key(input bit ext, input logic [7:0] b, input bit brk);
    int note, key, hit, slot;
    note = ref_note(ext, b);
    if (note == 0) return;
    key = {ext, b}; hit = -1;
    for (int i = 0; i < NV; i++) if (m_valid[i] && m_key[i] == key) hit = i;
    if (!brk) begin
      if (hit >= 0) return;
      slot = -1;
      for (int i = NV - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      if (slot < 0) begin slot = order.pop_back(); e_steal = 1; end
      m_valid[slot] = 1; m_key[slot] = key; m_note[slot] = note;
      order.push_front(slot);
      e_ev = 1; e_rel = 0; e_note = note;
    end else begin
      if (hit < 0) return;
      e_ev = 1; e_rel = 1; e_note = m_note[hit];
      m_valid[hit] = 0; m_note[hit] = 0;
      for (int i = 0; i < order.size(); i++) if (order[i] == hit) begin order.delete(i); break; end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit ext, brk;
    if (p_skip > 0) begin p_skip--; return; end
    if (!p_brk) begin
      if (b == 8'hE0) begin p_ext = 1; return; end
      if (b == 8'hF0) begin p_brk = 1; return; end
      if (b == 8'hE1 && !p_ext) begin p_skip = 7; return; end
    end
    ext = p_ext; brk = p_brk; p_ext = 0; p_brk = 0;
    apply_key(ext, b, brk);
  endtask

  function automatic logic [NV-1:0] exp_valid();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [NV*NW-1:0] exp_notes();
    logic [NV*NW-1:0] n;
    n = '0;
    for (int i = 0; i < NV; i++) if (m_valid[i]) n[i*NW +: NW] = NW'(m_note[i]);
    return n;
  endfunction

  // One clock: drive inputs, pass the edge, then advance the model by the
  // byte sampled one edge earlier so it lines up with the DUT outputs.
  task automatic step(input bit flag, input logic [7:0] data);
    iFlag = flag; iData = data;
    @(posedge iClk); #1;
    iFlag = 1'b0;
    e_ev = 0; e_steal = 0;
    if (pend) model_byte(pend_b);
    pend = flag; pend_b = data;
  endtask

  task automatic send(input logic [7:0] bytes[$]);
    foreach (bytes[i]) step(1'b1, bytes[i]);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    iReset_n = 1'b0; iFlag = 1'b0;
    @(posedge iClk); #1;
    model_reset();
    iReset_n = 1'b1;
    step(1'b0, 8'h00);
    ev_q = {}; ev_cyc = {};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_tests++;
    if ({oVoiceValid, oVoiceNote, oEvent, oEventRelease, oEventNote, oSteal} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b notes=%h ev=%b rel=%b note=%h steal=%b, need all zero",
               oVoiceValid, oVoiceNote, oEvent, oEventRelease, oEventNote, oSteal);
    end
    model_reset();
    iReset_n = 1'b1;
    @(negedge iClk);
  endtask

  task automatic test_make_break();
    do_reset();
    step(1'b1, 8'h1C);
    step(1'b0, 8'h00);
    n_tests++;
    if (oEvent !== 1'b1 || oEventRelease !== 1'b0 || oEventNote !== 8'd8 ||
        oVoiceValid !== 4'b0001 || oVoiceNote[7:0] !== 8'd8) begin
      n_fail++;
      $display("FAIL make_a: ev=%b rel=%b note=%0d valid=%b v0=%0d, need 1 0 8 0001 8",
               oEvent, oEventRelease, oEventNote, oVoiceValid, oVoiceNote[7:0]);
    end
    send('{8'hF0, 8'h1C});
    n_tests++;
    if (ev_q.size() != 2 || ev_q[1] !== {1'b1, 1'b0, 8'd8} || oVoiceValid !== 4'b0000 ||
        oVoiceNote !== '0 || oEventNote !== 8'd8) begin
      n_fail++;
      $display("FAIL break_a: events=%0d last=%h valid=%b notes=%h, need 2 208 0000 0",
               ev_q.size(), ev_q[ev_q.size()-1], oVoiceValid, oVoiceNote);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    send('{8'h1C, 8'h1C, 8'h1C});
    n_tests++;
    if (ev_q.size() != 1 || oVoiceValid !== 4'b0001 || oVoiceNote[7:0] !== 8'd8) begin
      n_fail++;
      $display("FAIL typematic: events=%0d valid=%b v0=%0d, need 1 0001 8",
               ev_q.size(), oVoiceValid, oVoiceNote[7:0]);
    end
  endtask

  task automatic test_steal();
    do_reset();
    send('{8'h1A, 8'h22, 8'h21, 8'h2A});
    n_tests++;
    if (ev_q.size() != 4 || oSteal !== 1'b0 || oVoiceNote !== {8'd4, 8'd3, 8'd2, 8'd1}) begin
      n_fail++;
      $display("FAIL fill4: events=%0d notes=%h, need 4 04030201", ev_q.size(), oVoiceNote);
    end
    step(1'b1, 8'h32);
    step(1'b0, 8'h00);
    n_tests++;
    if (oEvent !== 1'b1 || oSteal !== 1'b1 || oEventNote !== 8'd5 ||
        oVoiceValid !== 4'b1111 || oVoiceNote !== {8'd4, 8'd3, 8'd2, 8'd5}) begin
      n_fail++;
      $display("FAIL steal: ev=%b steal=%b note=%0d valid=%b notes=%h, need 1 1 5 1111 04030205",
               oEvent, oSteal, oEventNote, oVoiceValid, oVoiceNote);
    end
    step(1'b0, 8'h00);
    n_tests++;
    if (oSteal !== 1'b0 || oEvent !== 1'b0) begin
      n_fail++;
      $display("FAIL steal_pulse: steal=%b ev=%b one cycle later, need 0 0", oSteal, oEvent);
    end
    // Break of the stolen key (z) must stay silent.
    ev_q = {};
    send('{8'hF0, 8'h1A});
    n_tests++;
    if (ev_q.size() != 0 || oVoiceValid !== 4'b1111) begin
      n_fail++;
      $display("FAIL stolen_break: events=%0d valid=%b, need 0 1111", ev_q.size(), oVoiceValid);
    end
  endtask

  task automatic test_ext_pause();
    do_reset();
    send('{8'hE0, 8'h71, 8'hE0, 8'hF0, 8'h71});
    n_tests++;
    if (ev_q.size() != 2 || ev_q[0] !== {2'b00, 8'd56} || ev_q[1] !== {2'b10, 8'd56} ||
        oVoiceValid !== 4'b0000) begin
      n_fail++;
      $display("FAIL ext_del: events=%0d valid=%b, need 2 events make/break 56, 0000",
               ev_q.size(), oVoiceValid);
    end
    ev_q = {};
    send('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1B});
    n_tests++;
    if (ev_q.size() != 1 || ev_q[0] !== {2'b00, 8'd10} || oVoiceNote[7:0] !== 8'd10) begin
      n_fail++;
      $display("FAIL pause_skip: events=%0d first=%h v0=%0d, need 1 00a 10",
               ev_q.size(), ev_q.size() > 0 ? ev_q[0] : '0, oVoiceNote[7:0]);
    end
    ev_q = {};
    send('{8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C});
    n_tests++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL unmapped: events=%0d, need 0", ev_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 8'h1C);
    step(1'b1, 8'hE0);
    step(1'b1, 8'hF0);
    #2 iReset_n = 1'b0;
    #1;
    n_tests++;
    if (oVoiceValid !== '0 || oVoiceNote !== '0 || oEventNote !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b notes=%h note=%h, need zeros",
               oVoiceValid, oVoiceNote, oEventNote);
    end
    @(posedge iClk); #1;
    model_reset();
    iReset_n = 1'b1;
    ev_q = {};
    send('{8'h1B});
    n_tests++;
    if (ev_q.size() != 1 || ev_q[0] !== {2'b00, 8'd10} || oVoiceValid !== 4'b0001 ||
        oVoiceNote[7:0] !== 8'd10) begin
      n_fail++;
      $display("FAIL reset_mid: events=%0d valid=%b v0=%0d, need 1 make 10, 0001, 10",
               ev_q.size(), oVoiceValid, oVoiceNote[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[6] = '{8'h1C, 8'h1B, 8'hF0, 8'h1C, 8'hF0, 8'h1B};
    int samp[6];
    logic [NW+1:0] exp_ev[4] = '{{2'b00, 8'd8}, {2'b00, 8'd10}, {2'b10, 8'd8}, {2'b10, 8'd10}};
    int exp_at[4];
    do_reset();
    for (int i = 0; i < 6; i++) begin step(1'b1, seq[i]); samp[i] = cyc; end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    exp_at = '{samp[0] + 1, samp[1] + 1, samp[3] + 1, samp[5] + 1};
    n_tests++;
    if (ev_q.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_count: events=%0d, need 4", ev_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (ev_q[i] !== exp_ev[i] || ev_cyc[i] != exp_at[i]) begin
          n_fail++;
          $display("FAIL b2b_ev%0d: ev=%h at edge %0d, need %h at edge %0d",
                   i, ev_q[i], ev_cyc[i], exp_ev[i], exp_at[i]);
        end
      end
    end
    n_tests++;
    if (oVoiceValid !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_final: valid=%b, need 0000", oVoiceValid);
    end
  endtask

  task automatic test_random();
    logic [8:0] pool[11] = '{9'h01A, 9'h022, 9'h021, 9'h02A, 9'h032, 9'h03A,
                             9'h01C, 9'h01B, 9'h171, 9'h16C, 9'h11C};
    logic [7:0] bytes[$];
    logic [8:0] k;
    int bad = 0;
    do_reset();
    for (int a = 0; a < 400; a++) begin
      bytes = {};
      if ($urandom_range(0, 39) == 0) begin
        bytes = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      end else begin
        k = pool[$urandom_range(0, 10)];
        if (k[8]) bytes.push_back(8'hE0);
        if ($urandom_range(0, 1) == 1) bytes.push_back(8'hF0);
        bytes.push_back(k[7:0]);
      end
      foreach (bytes[i]) begin
        step(1'b1, bytes[i]);
        if ($urandom_range(0, 2) == 0) step(1'b0, 8'h00);
        n_tests++;
        if (oEvent !== e_ev || oSteal !== e_steal || (e_ev && oEventRelease !== e_rel) ||
            oEventNote !== NW'(e_note) || oVoiceValid !== exp_valid() || oVoiceNote !== exp_notes()) begin
          n_fail++;
          bad++;
          if (bad <= 10)
            $display("FAIL random@%0d: ev=%b rel=%b note=%0d steal=%b valid=%b notes=%h, need ev=%b rel=%b note=%0d steal=%b valid=%b notes=%h",
                     cyc, oEvent, oEventRelease, oEventNote, oSteal, oVoiceValid, oVoiceNote,
                     e_ev, e_rel, e_note, e_steal, exp_valid(), exp_notes());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make_break();
    test_typematic();
    test_steal();
    test_ext_pause();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
